// File: rtl/spi_flash_port.sv
// Memory-mapped SPI NOR flash read port (mode 0, single 0x03 or dual-output 0x3B read).
// Define SPI_FLASH_PREFETCH_EN to keep CS_N low after a read and stream sequential words.
module spi_flash_port #(
  parameter int unsigned ADDR_BITS    = 20,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUAL         = 0,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] word_address,
  input  logic                 rstrb,
  output logic [31:0]          rdata,
  output logic                 rbusy,
  output logic                 CLK,
  output logic                 CS_N,
  inout  wire                  MOSI,
  inout  wire                  MISO
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_MIN  = 2 * CLK_DIV - 1;
  localparam int unsigned GAP_W    = $clog2(2 * CLK_DIV + 1);
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DATA_LEN = (DUAL != 0) ? 16 : 32;
  localparam logic [7:0]  CMD_BYTE = (DUAL != 0) ? 8'h3B : 8'h03;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
`ifdef SPI_FLASH_PREFETCH_EN
  localparam logic [2:0] S_HOLD  = 3'd7;
`endif

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             csn_q, csn_d;
  logic             mosi_q, mosi_d;
  logic             mosi_oe_q, mosi_oe_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rbusy_q, rbusy_d;
`ifdef SPI_FLASH_PREFETCH_EN
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          last_word_q, last_word_d;
`endif

  logic             tick_c;
  logic [CNT_W-1:0] plen_c;
  logic [23:0]      byte_addr_c;
  logic [31:0]      word_c;

  assign tick_c      = (div_q == DIV_W'(CLK_DIV - 1));
  assign byte_addr_c = 24'({word_address, 2'b00});
  // First flash byte arrives in the top byte of the shifter; present it little-endian.
  assign word_c      = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};

  always_comb begin
    case (state_q)
      S_CMD:   plen_c = CNT_W'(8);
      S_ADDR:  plen_c = CNT_W'(24);
      S_DUMMY: plen_c = CNT_W'(DUMMY_CYCLES);
      default: plen_c = CNT_W'(DATA_LEN);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sck_d     = sck_q;
    csn_d     = csn_q;
    mosi_d    = mosi_q;
    mosi_oe_d = mosi_oe_q;
    sh_d      = sh_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    rbusy_d   = rbusy_q;
    gap_d     = csn_q ? ((gap_q == GAP_W'(GAP_MIN)) ? gap_q : gap_q + GAP_W'(1)) : '0;
`ifdef SPI_FLASH_PREFETCH_EN
    addr_d      = addr_q;
    last_word_d = last_word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rstrb) begin
          rbusy_d = 1'b1;
          sh_d    = {CMD_BYTE, byte_addr_c};
          state_d = S_START;
`ifdef SPI_FLASH_PREFETCH_EN
          addr_d  = word_address;
`endif
        end
      end
      // Hold CS_N high until the minimum deselect time has elapsed.
      S_START: begin
        if (gap_q == GAP_W'(GAP_MIN)) begin
          state_d   = S_CMD;
          csn_d     = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = sh_q[31];
          mosi_oe_d = 1'b1;
          div_d     = '0;
          cnt_d     = '0;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        if (tick_c && !sck_q) begin
          sck_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == S_DATA) begin
            data_d = (DUAL != 0) ? {data_q[29:0], MISO, MOSI} : {data_q[30:0], MISO};
            if (cnt_q == CNT_W'(DATA_LEN - 1)) state_d = S_DONE;
          end
        end else if (tick_c) begin
          sck_d  = 1'b0;
          sh_d   = {sh_q[30:0], 1'b0};
          mosi_d = sh_q[30];
          if (state_q != S_DATA && cnt_q == plen_c) begin
            cnt_d = '0;
            case (state_q)
              S_CMD: state_d = S_ADDR;
              S_ADDR: begin
                state_d   = (DUAL != 0 && DUMMY_CYCLES != 0) ? S_DUMMY : S_DATA;
                mosi_oe_d = (DUAL == 0);
              end
              default: state_d = S_DATA;
            endcase
          end
        end
      end
      S_DONE: begin
        sck_d   = 1'b0;
        rdata_d = word_c;
        rbusy_d = 1'b0;
`ifdef SPI_FLASH_PREFETCH_EN
        last_word_d = word_c;
        mosi_oe_d   = (DUAL == 0);
        state_d     = S_HOLD;
`else
        csn_d     = 1'b1;
        mosi_d    = 1'b0;
        mosi_oe_d = 1'b1;
        state_d   = S_IDLE;
`endif
      end
`ifdef SPI_FLASH_PREFETCH_EN
      // Flash still selected: same word replays, next word streams, anything else reselects.
      S_HOLD: begin
        if (rstrb) begin
          if (word_address == addr_q) begin
            rdata_d = last_word_q;
          end else if (word_address == addr_q + ADDR_BITS'(1)) begin
            rbusy_d = 1'b1;
            addr_d  = word_address;
            div_d   = '0;
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            rbusy_d   = 1'b1;
            addr_d    = word_address;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            mosi_oe_d = 1'b1;
            sh_d      = {CMD_BYTE, byte_addr_c};
            state_d   = S_START;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      sck_q     <= 1'b0;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      mosi_oe_q <= 1'b1;
      sh_q      <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      rbusy_q   <= 1'b0;
`ifdef SPI_FLASH_PREFETCH_EN
      addr_q      <= '0;
      last_word_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      sck_q     <= sck_d;
      csn_q     <= csn_d;
      mosi_q    <= mosi_d;
      mosi_oe_q <= mosi_oe_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      rbusy_q   <= rbusy_d;
`ifdef SPI_FLASH_PREFETCH_EN
      addr_q      <= addr_d;
      last_word_q <= last_word_d;
`endif
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;
  assign CLK   = sck_q;
  assign CS_N  = csn_q;
  assign MOSI  = mosi_oe_q ? mosi_q : 1'bz;
  assign MISO  = 1'bz;

endmodule

// File: tb/tb_spi_flash_port.sv
// Directed bench for spi_flash_port: channel 0 single read (CLK_DIV=1), channel 1 dual read (CLK_DIV=2),
// each against a behavioural flash whose byte[i] = i & 0xFF.
module tb_spi_flash_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rstrb [2];
  logic [19:0] waddr [2];
  wire  [31:0] rdata_w [2];
  wire         rbusy_w [2];
  wire         sck_w [2];
  wire         csn_w [2];
  wire         mosi_w [2];
  wire  [31:0] rises_w [2];
  wire  [31:0] falls_w [2];
  wire  [7:0]  cmd_w [2];
  wire  [23:0] adr_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    wire         mosi, miso;
    logic        f_oe0 = 1'b0, f_oe1 = 1'b0, f_io0 = 1'b0, f_io1 = 1'b0;
    int          cnt = 0, rises = 0, falls = 0, base = 0, k = 0;
    logic [7:0]  cmd = '0, b = '0;
    logic [23:0] adr = '0, a24 = '0;

    assign mosi = f_oe0 ? f_io0 : 1'bz;
    assign miso = f_oe1 ? f_io1 : 1'bz;
    assign mosi_w[g]  = mosi;
    assign rises_w[g] = rises;
    assign falls_w[g] = falls;
    assign cmd_w[g]   = cmd;
    assign adr_w[g]   = adr;

    spi_flash_port #(.ADDR_BITS(20), .CLK_DIV(g + 1), .DUAL(g), .DUMMY_CYCLES(8)) u_dut (
      .clk(clk), .reset(reset), .word_address(waddr[g]), .rstrb(rstrb[g]),
      .rdata(rdata_w[g]), .rbusy(rbusy_w[g]), .CLK(sck_w[g]), .CS_N(csn_w[g]),
      .MOSI(mosi), .MISO(miso));

    always @(negedge csn_w[g]) begin
      cnt = 0; falls++; f_oe0 = 1'b0; f_oe1 = 1'b0;
    end
    always @(posedge csn_w[g]) begin
      f_oe0 = 1'b0; f_oe1 = 1'b0;
    end
    always @(posedge sck_w[g]) begin
      if (!csn_w[g]) begin
        rises++;
        if (cnt < 8) cmd = {cmd[6:0], mosi};
        else if (cnt < 32) adr = {adr[22:0], mosi};
        cnt++;
      end
    end
    // Flash output changes after SCK falls; 0x3B adds 8 dummy clocks and drives two bits per clock.
    always @(negedge sck_w[g]) begin
      #1;
      if (!csn_w[g]) begin
        if (cmd == 8'h3B) begin
          base = 40;
          if (cnt >= base) begin
            k = cnt - base; a24 = adr + 24'(k / 4); b = a24[7:0];
            f_io1 = b[7 - 2 * (k % 4)]; f_io0 = b[6 - 2 * (k % 4)];
            f_oe0 = 1'b1; f_oe1 = 1'b1;
          end
        end else begin
          base = 32;
          if (cnt >= base) begin
            k = cnt - base; a24 = adr + 24'(k / 8); b = a24[7:0];
            f_io1 = b[7 - (k % 8)]; f_oe1 = 1'b1;
          end
        end
      end
    end
  end

  task automatic start_read(input int c, input logic [19:0] a);
    @(negedge clk); waddr[c] = a; rstrb[c] = 1'b1;
    @(negedge clk); rstrb[c] = 1'b0;
  endtask

  task automatic wait_idle(input int c, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!rbusy_w[c]) begin timed_out = 1'b0; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      n_cmp += 5;
      if (rdata_w[c] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata ch%0d: got %h expected 00000000", c, rdata_w[c]); end
      if (rbusy_w[c] !== 1'b0) begin n_bad++; $display("FAIL reset_rbusy ch%0d: got %b expected 0", c, rbusy_w[c]); end
      if (sck_w[c] !== 1'b0) begin n_bad++; $display("FAIL reset_clk ch%0d: got %b expected 0", c, sck_w[c]); end
      if (csn_w[c] !== 1'b1) begin n_bad++; $display("FAIL reset_csn ch%0d: got %b expected 1", c, csn_w[c]); end
      if (mosi_w[c] !== 1'b0) begin n_bad++; $display("FAIL reset_mosi ch%0d: got %b expected 0", c, mosi_w[c]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int r0, f0; bit to;
    r0 = int'(rises_w[0]); f0 = int'(falls_w[0]);
    start_read(0, 20'h00010);
    n_cmp++;
    if (rbusy_w[0] !== 1'b1) begin n_bad++; $display("FAIL single_rbusy: got %b expected 1", rbusy_w[0]); end
    wait_idle(0, 400, to);
    n_cmp += 6;
    if (to) begin n_bad++; $display("FAIL single_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[0] !== 32'h43424140) begin n_bad++; $display("FAIL single_rdata: got %h expected 43424140", rdata_w[0]); end
    if (int'(rises_w[0]) - r0 != 64) begin n_bad++; $display("FAIL single_sck: got %0d expected 64", int'(rises_w[0]) - r0); end
    if (int'(falls_w[0]) - f0 != 1) begin n_bad++; $display("FAIL single_cs: got %0d expected 1", int'(falls_w[0]) - f0); end
    if (cmd_w[0] !== 8'h03) begin n_bad++; $display("FAIL single_cmd: got %h expected 03", cmd_w[0]); end
    if (adr_w[0] !== 24'h000040) begin n_bad++; $display("FAIL single_addr: got %h expected 000040", adr_w[0]); end
  endtask

  task automatic test_dual_read();
    int r0; bit to;
    r0 = int'(rises_w[1]);
    start_read(1, 20'h00001);
    n_cmp++;
    if (rbusy_w[1] !== 1'b1) begin n_bad++; $display("FAIL dual_rbusy: got %b expected 1", rbusy_w[1]); end
    wait_idle(1, 800, to);
    n_cmp += 5;
    if (to) begin n_bad++; $display("FAIL dual_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[1] !== 32'h07060504) begin n_bad++; $display("FAIL dual_rdata: got %h expected 07060504", rdata_w[1]); end
    if (int'(rises_w[1]) - r0 != 56) begin n_bad++; $display("FAIL dual_sck: got %0d expected 56", int'(rises_w[1]) - r0); end
    if (cmd_w[1] !== 8'h3B) begin n_bad++; $display("FAIL dual_cmd: got %h expected 3b", cmd_w[1]); end
    if (adr_w[1] !== 24'h000004) begin n_bad++; $display("FAIL dual_addr: got %h expected 000004", adr_w[1]); end
  endtask

  task automatic test_ignore_busy();
    int f0; bit to;
    f0 = int'(falls_w[0]);
    start_read(0, 20'h00010);
    repeat (10) @(negedge clk);
    waddr[0] = 20'h00020; rstrb[0] = 1'b1;
    @(negedge clk); rstrb[0] = 1'b0;
    wait_idle(0, 400, to);
    repeat (20) @(negedge clk);
    n_cmp += 4;
    if (to) begin n_bad++; $display("FAIL busy_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[0] !== 32'h43424140) begin n_bad++; $display("FAIL busy_rdata: got %h expected 43424140", rdata_w[0]); end
    if (int'(falls_w[0]) - f0 != 1) begin n_bad++; $display("FAIL busy_cs: got %0d expected 1", int'(falls_w[0]) - f0); end
    if (adr_w[0] !== 24'h000040) begin n_bad++; $display("FAIL busy_addr: got %h expected 000040", adr_w[0]); end
  endtask

  task automatic test_reset_mid();
    int r0; bit to;
    r0 = int'(rises_w[0]);
    start_read(0, 20'h00008);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (int'(rises_w[0]) - r0 >= 40) begin to = 1'b0; break; end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 5;
    if (to) begin n_bad++; $display("FAIL midrst_reach40: got %0d edges expected 40", int'(rises_w[0]) - r0); end
    if (csn_w[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_csn: got %b expected 1", csn_w[0]); end
    if (sck_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_clk: got %b expected 0", sck_w[0]); end
    if (rbusy_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_rbusy: got %b expected 0", rbusy_w[0]); end
    if (rdata_w[0] !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h expected 00000000", rdata_w[0]); end
    reset = 1'b0;
    start_read(0, 20'h00000);
    wait_idle(0, 400, to);
    n_cmp += 2;
    if (to) begin n_bad++; $display("FAIL midrst_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[0] !== 32'h03020100) begin n_bad++; $display("FAIL midrst_rdata2: got %h expected 03020100", rdata_w[0]); end
  endtask

`ifdef SPI_FLASH_PREFETCH_EN
  task automatic test_prefetch();
    int r0, f0; bit to;
    start_read(0, 20'h00005); wait_idle(0, 400, to);
    n_cmp += 2;
    if (to) begin n_bad++; $display("FAIL pf_a_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[0] !== 32'h17161514) begin n_bad++; $display("FAIL pf_a_rdata: got %h expected 17161514", rdata_w[0]); end
    start_read(0, 20'h00010); wait_idle(0, 400, to);
    n_cmp += 1;
    if (rdata_w[0] !== 32'h43424140) begin n_bad++; $display("FAIL pf_b_rdata: got %h expected 43424140", rdata_w[0]); end
    r0 = int'(rises_w[0]); f0 = int'(falls_w[0]);
    start_read(0, 20'h00011);
    n_cmp++;
    if (rbusy_w[0] !== 1'b1) begin n_bad++; $display("FAIL pf_stream_rbusy: got %b expected 1", rbusy_w[0]); end
    wait_idle(0, 400, to);
    n_cmp += 5;
    if (to) begin n_bad++; $display("FAIL pf_stream_timeout: rbusy still 1 expected 0"); end
    if (rdata_w[0] !== 32'h47464544) begin n_bad++; $display("FAIL pf_stream_rdata: got %h expected 47464544", rdata_w[0]); end
    if (int'(rises_w[0]) - r0 != 32) begin n_bad++; $display("FAIL pf_stream_sck: got %0d expected 32", int'(rises_w[0]) - r0); end
    if (int'(falls_w[0]) - f0 != 0) begin n_bad++; $display("FAIL pf_stream_cs: got %0d expected 0", int'(falls_w[0]) - f0); end
    if (csn_w[0] !== 1'b0) begin n_bad++; $display("FAIL pf_stream_csn: got %b expected 0", csn_w[0]); end
    start_read(0, 20'h00011);
    n_cmp += 2;
    if (rbusy_w[0] !== 1'b0) begin n_bad++; $display("FAIL pf_repeat_rbusy: got %b expected 0", rbusy_w[0]); end
    if (rdata_w[0] !== 32'h47464544) begin n_bad++; $display("FAIL pf_repeat_rdata: got %h expected 47464544", rdata_w[0]); end
    start_read(0, 20'hFFFFF); wait_idle(0, 400, to);
    n_cmp += 1;
    if (rdata_w[0] !== 32'hFFFEFDFC) begin n_bad++; $display("FAIL pf_top_rdata: got %h expected fffefdfc", rdata_w[0]); end
    r0 = int'(rises_w[0]); f0 = int'(falls_w[0]);
    start_read(0, 20'h00000); wait_idle(0, 400, to);
    n_cmp += 3;
    if (rdata_w[0] !== 32'h03020100) begin n_bad++; $display("FAIL pf_wrap_rdata: got %h expected 03020100", rdata_w[0]); end
    if (int'(rises_w[0]) - r0 != 32) begin n_bad++; $display("FAIL pf_wrap_sck: got %0d expected 32", int'(rises_w[0]) - r0); end
    if (int'(falls_w[0]) - f0 != 0) begin n_bad++; $display("FAIL pf_wrap_cs: got %0d expected 0", int'(falls_w[0]) - f0); end
  endtask
`endif

  initial begin
    rstrb[0] = 1'b0; rstrb[1] = 1'b0;
    waddr[0] = '0;   waddr[1] = '0;
    test_reset();
    test_ignore_busy();
    test_reset_mid();
    test_single_read();
    test_dual_read();
`ifdef SPI_FLASH_PREFETCH_EN
    test_prefetch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
